sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-requester arbiter that shares one single-port synchronous SRAM between the CPU's instruction-fetch port and data-access port. It sits between the pipeline's fetch/memory stages and the unified memory. It uses a req/addr_ok/data_ok handshake on each side and keeps one registered request slot toward the SRAM. It routes in-order responses back to the owner, and a starvation counter bounds how long the data port can lock out the fetch port.

## Interface
- MEM_LAT, 1, cycles from SRAM acceptance (mem_en & mem_ready) to mem_rdata valid; legal 1..4
- STARVE_MAX, 4, maximum consecutive data grants while inst_req is pending; legal 1..15
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low)
- inst_req  in  1  fetch request; held with inst_addr stable until inst_addr_ok
- inst_addr  in  32  fetch byte address (word aligned)
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch response valid this cycle
- inst_rdata  out  32  fetch data; meaningful only with inst_data_ok
- data_req  in  1  data request; held with fields stable until data_addr_ok
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  4  byte enables for writes
- data_addr  in  32  data byte address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data response (read data or write ack) valid this cycle
- data_rdata  out  32  read data; meaningful only with data_data_ok
- mem_en  out  1  request to SRAM valid
- mem_we  out  4  byte write enables; 0 for reads
- mem_addr  out  32  SRAM address
- mem_wdata  out  32  SRAM write data
- mem_ready  in  1  SRAM accepts the presented request this cycle
- mem_rdata  in  32  SRAM read data, valid MEM_LAT cycles after acceptance

## Operation
- Request slot: registers valid, owner (0 = inst, 1 = data), we, addr, wdata. mem_en = slot valid, and mem_* come straight from the slot. Fields stay stable while mem_ready = 0.
- Slot is free when empty or when draining this cycle (valid & mem_ready). At most one addr_ok per cycle, and only when the slot is free. addr_ok is combinational from req, slot state and arbiter state.
- Fetch port is read-only. An inst request loads mem_we = 0 and wdata = 0.
- Data writes load mem_we = data_wstrb. Data reads load mem_we = 0.
- Arbiter FSM has two states.
  - DATA_PRI (reset state): if both requests are present, grant data and increment starve_cnt. If only one is present, grant it.
    - Move to INST_PRI when starve_cnt reaches STARVE_MAX with inst_req high.
  - INST_PRI: grant inst if inst_req; otherwise grant data if data_req. Either grant returns the FSM to DATA_PRI.
- starve_cnt (4 bit) clears on any inst grant, and whenever inst_req = 0.
- On SRAM acceptance, push {owner, 1} into a MEM_LAT-deep shift pipeline. Writes also push, producing a write ack.
- At the pipeline tail, pulse <owner>_data_ok for one cycle. Both rdata outputs = mem_rdata.
- Responses return in acceptance order, so program order between data writes and later reads is preserved.

## Timing
- Reset (resetn = 0, asynchronous): slot invalid, pipeline cleared, FSM = DATA_PRI, starve_cnt = 0.
  - Outputs: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Both addr_ok = 0 and both data_ok = 0. rdata outputs follow mem_rdata.
- Reset mid-operation: in-flight responses are dropped; no data_ok appears after resetn rises.
- Request accepted at cycle T (addr_ok = 1) appears on mem_* at T+1.
  - With mem_ready = 1 at T+1, data_ok is at T+1+MEM_LAT. For MEM_LAT = 1 that is T+2.
- Throughput: one request per cycle while mem_ready = 1. Each stall cycle adds one cycle to every following response.
- Slot full and mem_ready = 0: both addr_ok = 0 and the FSM/counter hold.
- Simultaneous drain and refill in one cycle are legal.
- Requester drops req before addr_ok: no grant and no effect on starve_cnt beyond the clear rule.

## Test plan
- MEM_LAT = 1, mem_ready = 1. inst_req at cycle 0, addr 0x1c000000 → inst_addr_ok cycle 0; mem_en = 1, mem_addr = 0x1c000000, mem_we = 0 at cycle 1; inst_data_ok = 1 at cycle 2 with inst_rdata = model word.
- STARVE_MAX = 4, both requests held high for 15 accepts → grant order D D D D I D D D D I D D D D I; no two addr_ok in one cycle.
- Slot full, mem_ready = 0 for cycles 3–5 → mem_en/addr/we/wdata constant, both addr_ok = 0; mem_ready = 1 at cycle 6 → accept, next request loads same cycle, data_ok at cycle 6+MEM_LAT.
- Data write addr 0x100, wstrb 4'b0011, wdata 0x12345678, then data read 0x100 → mem_we = 4'b0011 then 4'b0000; two data_data_ok in order; read returns 0x????5678 upper bytes preserved.
- MEM_LAT = 3, alternating inst/data reads back-to-back → each data_ok exactly 3 cycles after its SRAM acceptance, routed to the correct port, never both in one cycle.
- resetn asserted while two reads are in flight → mem_en = 0 immediately, no data_ok after release, first post-reset request behaves as the first scenario.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between the fetch port and the data port, with a starvation bound on fetch.
// Latency: addr_ok at T -> mem_* at T+1 -> <owner>_data_ok at T+1+MEM_LAT when mem_ready is high at T+1.
// Backpressure: mem_ready low holds the request slot; both addr_ok stay low until the slot drains.
module sram_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {DATA_PRI, INST_PRI} arb_state_t;

    arb_state_t         state;
    logic [3:0]         starve_cnt;
    logic [3:0]         starve_inc;

    logic               slot_vld;
    logic               slot_owner;
    logic [3:0]         slot_we;
    logic [31:0]        slot_addr;
    logic [31:0]        slot_wdata;

    logic               slot_free;
    logic               mem_accept;
    logic               grant_inst;
    logic               grant_data;

    logic [MEM_LAT-1:0] pipe_vld;
    logic [MEM_LAT-1:0] pipe_owner;

    assign mem_accept = slot_vld & mem_ready;
    assign slot_free  = ~slot_vld | mem_ready;
    assign starve_inc = starve_cnt + 4'd1;

    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (slot_free) begin
            if (state == INST_PRI) begin
                if (inst_req)      grant_inst = 1'b1;
                else if (data_req) grant_data = 1'b1;
            end else begin
                if (data_req)      grant_data = 1'b1;
                else if (inst_req) grant_inst = 1'b1;
            end
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    // The counter only advances on data grants that jump ahead of a waiting fetch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= DATA_PRI;
            starve_cnt <= 4'd0;
        end else begin
            if (!inst_req || grant_inst)
                starve_cnt <= 4'd0;
            else if (grant_data && state == DATA_PRI)
                starve_cnt <= starve_inc;

            if (grant_inst || grant_data) begin
                if (state == DATA_PRI && grant_data && inst_req &&
                    starve_inc >= 4'(STARVE_MAX))
                    state <= INST_PRI;
                else
                    state <= DATA_PRI;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_vld   <= 1'b0;
            slot_owner <= 1'b0;
            slot_we    <= 4'd0;
            slot_addr  <= 32'd0;
            slot_wdata <= 32'd0;
        end else if (grant_inst || grant_data) begin
            slot_vld   <= 1'b1;
            slot_owner <= grant_data;
            slot_we    <= (grant_data && data_wr) ? data_wstrb : 4'd0;
            slot_addr  <= grant_data ? data_addr : inst_addr;
            slot_wdata <= grant_data ? data_wdata : 32'd0;
        end else if (mem_accept) begin
            slot_vld   <= 1'b0;
        end
    end

    assign mem_en    = slot_vld;
    assign mem_we    = slot_we;
    assign mem_addr  = slot_addr;
    assign mem_wdata = slot_wdata;

    // Writes travel the pipeline too so their ack keeps acceptance order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pipe_vld   <= '0;
            pipe_owner <= '0;
        end else begin
            pipe_vld[0]   <= mem_accept;
            pipe_owner[0] <= slot_owner;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_vld[i]   <= pipe_vld[i-1];
                pipe_owner[i] <= pipe_owner[i-1];
            end
        end
    end

    assign inst_data_ok = pipe_vld[MEM_LAT-1] & ~pipe_owner[MEM_LAT-1];
    assign data_data_ok = pipe_vld[MEM_LAT-1] &  pipe_owner[MEM_LAT-1];
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: DUT a runs MEM_LAT=1, DUT b runs MEM_LAT=3; each has a byte-strobed SRAM model.
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        a_inst_req, a_inst_addr_ok, a_inst_data_ok;
    logic [31:0] a_inst_addr, a_inst_rdata;
    logic        a_data_req, a_data_wr, a_data_addr_ok, a_data_data_ok;
    logic [3:0]  a_data_wstrb;
    logic [31:0] a_data_addr, a_data_wdata, a_data_rdata;
    logic        a_mem_en, a_mem_ready;
    logic [3:0]  a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b_inst_req, b_inst_addr_ok, b_inst_data_ok;
    logic [31:0] b_inst_addr, b_inst_rdata;
    logic        b_data_req, b_data_wr, b_data_addr_ok, b_data_data_ok;
    logic [3:0]  b_data_wstrb;
    logic [31:0] b_data_addr, b_data_wdata, b_data_rdata;
    logic        b_mem_en, b_mem_ready;
    logic [3:0]  b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    sram_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut_a (
        .clk(clk), .resetn(resetn),
        .inst_req(a_inst_req), .inst_addr(a_inst_addr), .inst_addr_ok(a_inst_addr_ok),
        .inst_data_ok(a_inst_data_ok), .inst_rdata(a_inst_rdata),
        .data_req(a_data_req), .data_wr(a_data_wr), .data_wstrb(a_data_wstrb),
        .data_addr(a_data_addr), .data_wdata(a_data_wdata), .data_addr_ok(a_data_addr_ok),
        .data_data_ok(a_data_data_ok), .data_rdata(a_data_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_ready(a_mem_ready), .mem_rdata(a_mem_rdata)
    );

    sram_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .resetn(resetn),
        .inst_req(b_inst_req), .inst_addr(b_inst_addr), .inst_addr_ok(b_inst_addr_ok),
        .inst_data_ok(b_inst_data_ok), .inst_rdata(b_inst_rdata),
        .data_req(b_data_req), .data_wr(b_data_wr), .data_wstrb(b_data_wstrb),
        .data_addr(b_data_addr), .data_wdata(b_data_wdata), .data_addr_ok(b_data_addr_ok),
        .data_data_ok(b_data_data_ok), .data_rdata(b_data_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_ready(b_mem_ready), .mem_rdata(b_mem_rdata)
    );

    // SRAM models: word i initialised to 0xC0DE0000 + i, indexed by addr[9:2].
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic        mem_a_init = 1'b0;
    logic        mem_b_init = 1'b0;
    logic [31:0] a_rd;
    logic [31:0] b_rd [3];

    assign a_mem_rdata = a_rd;
    assign b_mem_rdata = b_rd[2];

    always @(posedge clk) begin
        if (!mem_a_init) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= 32'hC0DE0000 + i;
            mem_a_init <= 1'b1;
        end else if (a_mem_en && a_mem_ready) begin
            for (int b = 0; b < 4; b++)
                if (a_mem_we[b]) mem_a[a_mem_addr[9:2]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
            a_rd <= mem_a[a_mem_addr[9:2]];
        end
    end

    always @(posedge clk) begin
        if (!mem_b_init) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= 32'hC0DE0000 + i;
            mem_b_init <= 1'b1;
        end
        b_rd[0] <= (b_mem_en && b_mem_ready) ? mem_b[b_mem_addr[9:2]] : 32'hDEADBEEF;
        b_rd[1] <= b_rd[0];
        b_rd[2] <= b_rd[1];
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic a_idle();
        a_inst_req = 1'b0; a_inst_addr = 32'd0;
        a_data_req = 1'b0; a_data_wr = 1'b0; a_data_wstrb = 4'd0;
        a_data_addr = 32'd0; a_data_wdata = 32'd0;
    endtask

    // Single fetch at 0x1c000000: accept, present, respond.
    task automatic first_fetch(input string pfx);
        @(negedge clk);
        a_inst_req = 1'b1; a_inst_addr = 32'h1c000000;
        #1;
        chk({pfx, "_inst_addr_ok"}, a_inst_addr_ok, 1);
        chk({pfx, "_data_addr_ok"}, a_data_addr_ok, 0);
        @(negedge clk);
        a_inst_req = 1'b0;
        #1;
        chk({pfx, "_mem_en"}, a_mem_en, 1);
        chk({pfx, "_mem_addr"}, a_mem_addr, 32'h1c000000);
        chk({pfx, "_mem_we"}, a_mem_we, 0);
        chk({pfx, "_early_data_ok"}, a_inst_data_ok, 0);
        @(negedge clk);
        #1;
        chk({pfx, "_inst_data_ok"}, a_inst_data_ok, 1);
        chk({pfx, "_inst_rdata"}, a_inst_rdata, 32'hC0DE0000);
        chk({pfx, "_no_data_data_ok"}, a_data_data_ok, 0);
        @(negedge clk);
        #1;
        chk({pfx, "_data_ok_pulse"}, a_inst_data_ok, 0);
    endtask

    string  order;
    logic   exp_i;
    logic   ei, ed;
    logic [31:0] erd;

    initial begin
        a_idle();
        a_mem_ready = 1'b1;
        b_inst_req = 1'b0; b_inst_addr = 32'd0;
        b_data_req = 1'b0; b_data_wr = 1'b0; b_data_wstrb = 4'd0;
        b_data_addr = 32'd0; b_data_wdata = 32'd0;
        b_mem_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_en", a_mem_en, 0);
        chk("rst_mem_we", a_mem_we, 0);
        chk("rst_mem_addr", a_mem_addr, 0);
        chk("rst_mem_wdata", a_mem_wdata, 0);
        chk("rst_inst_data_ok", a_inst_data_ok, 0);
        chk("rst_data_data_ok", a_data_data_ok, 0);
        @(negedge clk);
        resetn = 1'b1;

        first_fetch("fetch");

        // Starvation bound with both requests held
        order = "DDDDIDDDDIDDDDI";
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            a_inst_req = 1'b1; a_inst_addr = 32'h1c000004;
            a_data_req = 1'b1; a_data_addr = 32'h200;
            #1;
            exp_i = (order[c] == "I");
            chk($sformatf("starve_inst_ok_%0d", c), a_inst_addr_ok, exp_i);
            chk($sformatf("starve_data_ok_%0d", c), a_data_addr_ok, !exp_i);
        end
        @(negedge clk);
        a_idle();
        repeat (3) @(negedge clk);

        // Stall with the slot full, then drain and refill together
        @(negedge clk);
        a_data_req = 1'b1; a_data_addr = 32'h44;
        #1;
        chk("stall_accept", a_data_addr_ok, 1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            a_data_req = 1'b0; a_mem_ready = 1'b0;
            a_inst_req = 1'b1; a_inst_addr = 32'h1c000008;
            #1;
            chk($sformatf("stall_mem_en_%0d", c), a_mem_en, 1);
            chk($sformatf("stall_mem_addr_%0d", c), a_mem_addr, 32'h44);
            chk($sformatf("stall_mem_we_%0d", c), a_mem_we, 0);
            chk($sformatf("stall_mem_wdata_%0d", c), a_mem_wdata, 0);
            chk($sformatf("stall_inst_ok_%0d", c), a_inst_addr_ok, 0);
            chk($sformatf("stall_data_ok_%0d", c), a_data_data_ok, 0);
        end
        @(negedge clk);
        a_mem_ready = 1'b1;
        #1;
        chk("refill_inst_ok", a_inst_addr_ok, 1);
        chk("refill_mem_addr", a_mem_addr, 32'h44);
        @(negedge clk);
        a_inst_req = 1'b0;
        #1;
        chk("refill_mem_addr2", a_mem_addr, 32'h1c000008);
        chk("stall_resp_ok", a_data_data_ok, 1);
        chk("stall_resp_rdata", a_data_rdata, 32'hC0DE0011);
        @(negedge clk);
        #1;
        chk("refill_resp_ok", a_inst_data_ok, 1);
        chk("refill_resp_rdata", a_inst_rdata, 32'hC0DE0002);
        chk("refill_idle_en", a_mem_en, 0);

        // Partial write followed by a read of the same word
        @(negedge clk);
        a_data_req = 1'b1; a_data_wr = 1'b1; a_data_wstrb = 4'b0011;
        a_data_addr = 32'h100; a_data_wdata = 32'h12345678;
        #1;
        chk("wr_addr_ok", a_data_addr_ok, 1);
        @(negedge clk);
        a_data_wr = 1'b0; a_data_wstrb = 4'd0; a_data_wdata = 32'd0;
        #1;
        chk("rd_addr_ok", a_data_addr_ok, 1);
        chk("wr_mem_we", a_mem_we, 4'b0011);
        chk("wr_mem_wdata", a_mem_wdata, 32'h12345678);
        chk("wr_mem_addr", a_mem_addr, 32'h100);
        @(negedge clk);
        a_idle();
        #1;
        chk("rd_mem_we", a_mem_we, 0);
        chk("rd_mem_addr", a_mem_addr, 32'h100);
        chk("wr_ack", a_data_data_ok, 1);
        @(negedge clk);
        #1;
        chk("rd_resp_ok", a_data_data_ok, 1);
        chk("rd_resp_rdata", a_data_rdata, 32'hC0DE5678);
        @(negedge clk);
        #1;
        chk("rd_resp_done", a_data_data_ok, 0);

        // MEM_LAT=3: alternating fetch/data reads back to back
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            b_inst_req = (c == 0 || c == 2);
            b_data_req = (c == 1 || c == 3);
            b_inst_addr = (c == 0) ? 32'h1c000010 : 32'h1c000014;
            b_data_addr = (c == 1) ? 32'h20 : 32'h24;
            #1;
            if (c < 4) begin
                chk($sformatf("lat3_inst_aok_%0d", c), b_inst_addr_ok, (c == 0 || c == 2));
                chk($sformatf("lat3_data_aok_%0d", c), b_data_addr_ok, (c == 1 || c == 3));
            end
            ei = (c == 4 || c == 6);
            ed = (c == 5 || c == 7);
            chk($sformatf("lat3_inst_dok_%0d", c), b_inst_data_ok, ei);
            chk($sformatf("lat3_data_dok_%0d", c), b_data_data_ok, ed);
            if (ei || ed) begin
                erd = (c == 4) ? 32'hC0DE0004 : (c == 5) ? 32'hC0DE0008 :
                      (c == 6) ? 32'hC0DE0005 : 32'hC0DE0009;
                chk($sformatf("lat3_rdata_%0d", c), ei ? b_inst_rdata : b_data_rdata, erd);
            end
        end

        // Reset with two reads in flight
        @(negedge clk);
        a_data_req = 1'b1; a_data_addr = 32'h30;
        #1;
        chk("rstmid_aok0", a_data_addr_ok, 1);
        @(negedge clk);
        a_data_addr = 32'h34;
        #1;
        chk("rstmid_aok1", a_data_addr_ok, 1);
        #1;
        resetn = 1'b0;
        a_idle();
        #1;
        chk("rstmid_mem_en", a_mem_en, 0);
        chk("rstmid_data_ok", a_data_data_ok, 0);
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_rst_data_ok_%0d", c), a_data_data_ok, 0);
            chk($sformatf("post_rst_inst_ok_%0d", c), a_inst_data_ok, 0);
        end
        first_fetch("refetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
